// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_DIVZERO = 2'b01,
    DIV_RUN     = 2'b10,
    DIV_DONE    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivSigned         = 1'b1;
  localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/ex_div_unit.sv
// Restoring radix-2 divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}; remainder takes the dividend's sign.
module ex_div_unit
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                annul,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opa,
  input  logic [DATA_W-1:0]   opb,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                busy
);

  div_state_e                state_r, state_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic [DATA_W-1:0]         dvd_r, dvd_s;
  logic [DATA_W-1:0]         dvs_r, dvs_s;
  logic [DATA_W-1:0]         rem_r, rem_s;
  logic                      sign_a_r, sign_a_s;
  logic                      sign_q_r, sign_q_s;
  logic [2*DATA_W-1:0]       result_r, result_s;
  logic                      ready_r, ready_s;
  logic                      busy_r, busy_s;
  logic [2*DATA_W-1:0]       step_s;
  logic [DATA_W-1:0]         q_fix_s;
  logic [DATA_W-1:0]         r_fix_s;
  logic                      sign_opa_s;
  logic                      sign_opb_s;

  // Shift {rem, dvd} left and trial-subtract; returns {new_rem, new_dvd}.
  // Because rem < dvs, the shifted value is < 2*dvs, so bit DATA_W of the
  // DATA_W+1-bit difference is exactly the borrow.
  function automatic logic [2*DATA_W-1:0] div_step(
    input logic [DATA_W-1:0] rem,
    input logic [DATA_W-1:0] dvd,
    input logic [DATA_W-1:0] dvs
  );
    logic [DATA_W:0] shl;
    logic [DATA_W:0] diff;
    shl  = {rem, dvd[DATA_W-1]};
    diff = shl - {1'b0, dvs};
    if (diff[DATA_W] == 1'b0) begin
      div_step = {diff[DATA_W-1:0], dvd[DATA_W-2:0], 1'b1};
    end else begin
      div_step = {shl[DATA_W-1:0], dvd[DATA_W-2:0], 1'b0};
    end
  endfunction

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    dvd_s      = dvd_r;
    dvs_s      = dvs_r;
    rem_s      = rem_r;
    sign_a_s   = sign_a_r;
    sign_q_s   = sign_q_r;
    result_s   = result_r;
    step_s     = div_step(rem_r, dvd_r, dvs_r);
    sign_opa_s = (signed_div == DivSigned) & opa[DATA_W-1];
    sign_opb_s = (signed_div == DivSigned) & opb[DATA_W-1];
    if (sign_q_r) begin
      q_fix_s = {DATA_W{1'b0}} - step_s[DATA_W-1:0];
    end else begin
      q_fix_s = step_s[DATA_W-1:0];
    end
    if (sign_a_r) begin
      r_fix_s = {DATA_W{1'b0}} - step_s[2*DATA_W-1:DATA_W];
    end else begin
      r_fix_s = step_s[2*DATA_W-1:DATA_W];
    end

    if (annul) begin
      state_s  = DIV_IDLE;
      result_s = {(2*DATA_W){1'b0}};
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start == DivStart) begin
            if (opb == {DATA_W{1'b0}}) begin
              state_s = DIV_DIVZERO;
            end else begin
              state_s  = DIV_RUN;
              dvd_s    = sign_opa_s ? ({DATA_W{1'b0}} - opa) : opa;
              dvs_s    = sign_opb_s ? ({DATA_W{1'b0}} - opb) : opb;
              sign_a_s = sign_opa_s;
              sign_q_s = sign_opa_s ^ sign_opb_s;
              cnt_s    = {CNT_W{1'b0}};
              rem_s    = {DATA_W{1'b0}};
            end
          end else begin
            state_s = DIV_IDLE;
          end
        end
        DIV_DIVZERO: begin
          state_s  = DIV_DONE;
          result_s = {(2*DATA_W){1'b0}};
        end
        DIV_RUN: begin
          rem_s = step_s[2*DATA_W-1:DATA_W];
          dvd_s = step_s[DATA_W-1:0];
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(DATA_W-1)) begin
            state_s  = DIV_DONE;
            result_s = {r_fix_s, q_fix_s};
          end else begin
            state_s = DIV_RUN;
          end
        end
        DIV_DONE: begin
          if (start == DivStart) begin
            state_s = DIV_DONE;
          end else begin
            state_s  = DIV_IDLE;
            result_s = {(2*DATA_W){1'b0}};
          end
        end
        default: begin
          state_s  = DIV_IDLE;
          result_s = {(2*DATA_W){1'b0}};
        end
      endcase
    end

    if (state_s == DIV_IDLE) begin
      busy_s = 1'b0;
    end else begin
      busy_s = 1'b1;
    end
    if (state_s == DIV_DONE) begin
      ready_s = DivResultReady;
    end else begin
      ready_s = DivResultNotReady;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= DIV_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      dvd_r    <= {DATA_W{1'b0}};
      dvs_r    <= {DATA_W{1'b0}};
      rem_r    <= {DATA_W{1'b0}};
      sign_a_r <= 1'b0;
      sign_q_r <= 1'b0;
      result_r <= {(2*DATA_W){1'b0}};
      ready_r  <= DivResultNotReady;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      dvd_r    <= dvd_s;
      dvs_r    <= dvs_s;
      rem_r    <= rem_s;
      sign_a_r <= sign_a_s;
      sign_q_r <= sign_q_s;
      result_r <= result_s;
      ready_r  <= ready_s;
      busy_r   <= busy_s;
    end
  end

  assign result = result_r;
  assign ready  = ready_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: vector table plus
// hand sequences for annul, dropped start and asynchronous reset.
module tb_ex_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves start high with the unit in DONE.
  task automatic do_div(input string name, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                        input int mangle_at);
    int   lat;
    logic busy_ok;
    signed_div = sd;
    opa        = a;
    opb        = b;
    annul      = 1'b0;
    start      = 1'b1;
    lat        = 0;
    busy_ok    = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == mangle_at) begin
        opa        = $urandom;
        opb        = $urandom;
        signed_div = ~sd;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ready === 1'b1) lat = c;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " busy"}, {63'd0, busy_ok}, 64'd1);
    chk({name, " result"}, result, exp);
  endtask

  // Drop start in DONE; one edge later the unit is idle and cleared.
  task automatic end_div(input string name);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " drop ready"}, {63'd0, ready}, 64'd0);
    chk({name, " drop busy"}, {63'd0, busy}, 64'd0);
    chk({name, " drop result"}, result, 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;

    vecs[0] = '{"divu_100_7",  1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 33};
    vecs[1] = '{"div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
    vecs[2] = '{"div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33};
    vecs[3] = '{"divzero",     1'b0, 32'h12345678,   32'd0,          64'd0,                        2};
    vecs[4] = '{"div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33};
    vecs[5] = '{"divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 33};
    vecs[6] = '{"div_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 33};
    vecs[7] = '{"divu_fff9_2", 1'b0, 32'hFFFFFFF9,   32'd2,          {32'h00000001, 32'h7FFFFFFC}, 33};
    vecs[8] = '{"divu_5_9",    1'b0, 32'd5,          32'd9,          {32'h00000005, 32'h00000000}, 33};

    rst        = 1'b1;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opa        = 32'd0;
    opb        = 32'd0;
    #1;
    chk("reset result", result, 64'd0);
    chk("reset ready", {63'd0, ready}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Chained vectors also exercise back-to-back starts after one idle cycle.
    for (int i = 0; i < 9; i++) begin
      do_div(vecs[i].name, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
      end_div(vecs[i].name);
    end

    // Operand/mode changes during RUN must not disturb the result.
    do_div("mangle", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 33, 5);
    end_div("mangle");

    // Annul at cycle 10 with start still high: annul wins.
    signed_div = 1'b0;
    opa        = 32'd100;
    opb        = 32'd7;
    start      = 1'b1;
    seen       = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    chk("annul busy before", {63'd0, busy}, 64'd1);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul busy", {63'd0, busy}, 64'd0);
    chk("annul ready", {63'd0, ready | seen}, 64'd0);
    chk("annul result", result, 64'd0);
    do_div("annul_restart", 1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, 33, 0);
    end_div("annul_restart");

    // Start dropped early in RUN: still completes, ready for exactly one cycle.
    signed_div = 1'b0;
    opa        = 32'd100;
    opb        = 32'd7;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int c = 2; c <= 40 && lat == 0; c++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) lat = c;
    end
    chk("early_drop latency", 64'(lat), 64'd33);
    chk("early_drop result", result, {32'h00000002, 32'h0000000E});
    @(posedge clk);
    #1;
    chk("early_drop idle ready", {63'd0, ready}, 64'd0);
    chk("early_drop idle busy", {63'd0, busy}, 64'd0);

    // Async reset while holding a DONE result.
    do_div("rst_done", 1'b0, 32'd1000, 32'd10, {32'h00000000, 32'h00000064}, 33, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_done result", result, 64'd0);
    chk("rst_done ready", {63'd0, ready}, 64'd0);
    chk("rst_done busy", {63'd0, busy}, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Async reset between edges during RUN.
    signed_div = 1'b0;
    opa        = 32'd100;
    opb        = 32'd7;
    start      = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_run busy before", {63'd0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_run busy", {63'd0, busy}, 64'd0);
    chk("rst_run ready", {63'd0, ready}, 64'd0);
    chk("rst_run result", result, 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_div("after_rst", 1'b0, 32'hFFFFFFFF, 32'h00010000, {32'h0000FFFF, 32'h0000FFFF}, 33, 0);
    end_div("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
